sample_packer: RTL and testbench

SAMPLE_PACKER -- requirements
Module: sample_packer

---
 rtl/sample_packer_pkg.sv | 33 +++
 rtl/field_extract.sv | 42 ++++
 rtl/sample_packer.sv | 215 +++++++++++++++++++++
 tb/tb_sample_packer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sample_packer_pkg
//  Description : Shared definitions for the sample packer: output word width,
//                channel-count ceiling, field-width encodings, the active
//                configuration record and a field-width decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package sample_packer_pkg;

    localparam int OW      = 16;   // packed output word width
    localparam int NCH_MAX = 8;    // largest supported channel-pair count
    localparam int FW_MAX  = 8;    // widest extractable field

    // cfg_bits encodings of the per-component field width B
    localparam logic [1:0] FW_1 = 2'd0;
    localparam logic [1:0] FW_2 = 2'd1;
    localparam logic [1:0] FW_4 = 2'd2;
    localparam logic [1:0] FW_8 = 2'd3;

    typedef struct packed {
        logic [NCH_MAX-1:0] mask;   // channel enables, bit k = channel k
        logic [1:0]         bits;   // field width encoding (FW_*)
        logic [2:0]         shift;  // MSB offset of the field window
    } cfg_t;

    // Decode a cfg_bits encoding into the field width B (1, 2, 4 or 8).
    function automatic int unsigned field_width(input logic [1:0] enc);
        return 32'd1 << enc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/field_extract.sv
`default_nettype none
// ============================================================================
//  Module      : field_extract
//  Description : Extracts a B-bit field from one offset-binary sample, with
//                its MSB at bit (SW-1-s), s = min(shift, SW-B). The field is
//                returned left-justified in an FW_MAX-bit vector, lower bits 0.
//  Ports       : sample_i  - input sample (SW bits)
//                bits_i    - field width encoding (FW_*)
//                shift_i   - requested MSB offset
//                field_o   - left-justified field
//  Revision    : 1.0  initial release
// ============================================================================
module field_extract
    import sample_packer_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic [SW-1:0]     sample_i,
    input  logic [1:0]        bits_i,
    input  logic [2:0]        shift_i,
    output logic [FW_MAX-1:0] field_o
);

    always_comb begin
        logic [SW+FW_MAX-1:0] v_ext;
        int                   v_b;
        int                   v_s;
        v_b = int'(field_width(bits_i));
        v_s = int'(shift_i);
        // Clamp so the window never runs past the sample LSB.
        if (v_s > SW - v_b) v_s = SW - v_b;
        if (v_s < 0)        v_s = 0;
        v_ext   = {sample_i, {FW_MAX{1'b0}}} << v_s;
        field_o = v_ext[SW+FW_MAX-1 -: FW_MAX];
        // Keep only the top B bits.
        for (int j = 0; j < FW_MAX; j++) begin
            if (j < FW_MAX - v_b) field_o[j] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : sample_packer
//  Description : Extracts a configurable bit field from each enabled I/Q
//                sample pair, concatenates them MSB-first and packs the
//                bitstream into OW-bit words with a valid/ready output,
//                overflow (drop) counting and an emitted-word counter.
//  Ports       : clk, reset_n (async, active low)
//                in_i/in_q/in_en          - sample input
//                cfg_mask/bits/shift/apply - configuration load
//                out_data/out_valid/out_ready - word output handshake
//                cfg_err, overflow_count, word_count - status
//  Revision    : 1.0  initial release
// ============================================================================
module sample_packer #(
    parameter int NCH = 4,
    parameter int SW  = 8,
    parameter int OW  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH*SW-1:0] in_i,
    input  logic [NCH*SW-1:0] in_q,
    input  logic              in_en,
    input  logic [NCH-1:0]    cfg_mask,
    input  logic [1:0]        cfg_bits,
    input  logic [2:0]        cfg_shift,
    input  logic              cfg_apply,
    output logic [OW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              cfg_err,
    output logic [15:0]       overflow_count,
    output logic [15:0]       word_count
);

    import sample_packer_pkg::*;

    // Fill can reach 2*OW-1 before a word is taken out.
    localparam int                FILL_W     = $clog2(2 * OW) + 1;
    localparam logic [FILL_W-1:0] C_OW_FILL  = FILL_W'(OW);

    // Configuration is invalid when the mask is empty or one in_en cycle
    // would produce more bits than fit in a single output word.
    function automatic logic cfg_invalid(input cfg_t c);
        int pop;
        pop = 0;
        for (int k = 0; k < NCH_MAX; k++) pop = pop + int'(c.mask[k]);
        return (pop == 0) || (2 * int'(field_width(c.bits)) * pop > OW);
    endfunction

    function automatic cfg_t reset_cfg();
        cfg_t c;
        c       = '0;
        c.bits  = FW_2;
        c.shift = 3'd0;
        for (int k = 0; k < NCH; k++) c.mask[k] = 1'b1;
        return c;
    endfunction

    localparam cfg_t C_CFG_RST = reset_cfg();
    localparam logic C_ERR_RST = cfg_invalid(C_CFG_RST);

    cfg_t                cfg_q, cfg_d;
    logic                cfg_err_q, cfg_err_d;
    logic [2*OW-1:0]     acc_q, acc_d;     // oldest bit at the MSB
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [OW-1:0]       out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [15:0]         ovf_q, ovf_d;
    logic [15:0]         wc_q, wc_d;

    logic [FW_MAX-1:0]   w_fld_i [NCH];
    logic [FW_MAX-1:0]   w_fld_q [NCH];
    logic [OW-1:0]       w_new;            // this cycle's bits, left-justified
    logic [FILL_W-1:0]   w_nbits;
    logic [FILL_W-1:0]   w_fill_sum;
    logic [2*OW-1:0]     w_acc_new;
    logic                w_done;

    // ------------------------------------------------------------------
    // Field extraction, one instance per component
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        field_extract #(.SW(SW)) u_fe_i (
            .sample_i (in_i[k*SW +: SW]),
            .bits_i   (cfg_q.bits),
            .shift_i  (cfg_q.shift),
            .field_o  (w_fld_i[k])
        );
        field_extract #(.SW(SW)) u_fe_q (
            .sample_i (in_q[k*SW +: SW]),
            .bits_i   (cfg_q.bits),
            .shift_i  (cfg_q.shift),
            .field_o  (w_fld_q[k])
        );
    end

    // ------------------------------------------------------------------
    // Serialise enabled fields: ascending channel, I then Q, MSB first.
    // ------------------------------------------------------------------
    always_comb begin
        logic [OW-1:0]     v_tmp;
        logic [FW_MAX-1:0] v_f;
        int                v_b;
        int                v_pos;
        v_tmp = '0;
        v_f   = '0;
        v_b   = int'(field_width(cfg_q.bits));
        v_pos = 0;
        for (int k = 0; k < NCH; k++) begin
            if (cfg_q.mask[k]) begin
                for (int c = 0; c < 2; c++) begin
                    v_f = (c == 0) ? w_fld_i[k] : w_fld_q[k];
                    for (int j = 0; j < FW_MAX; j++) begin
                        if (j < v_b) begin
                            v_tmp = {v_tmp[OW-2:0], v_f[FW_MAX-1]};
                            v_f   = v_f << 1;
                            v_pos = v_pos + 1;
                        end
                    end
                end
            end
        end
        // Oversized patterns only occur with cfg_err set, where they are unused.
        if (v_pos > OW) v_pos = OW;
        w_new   = v_tmp << (OW - v_pos);
        w_nbits = FILL_W'(v_pos);
    end

    assign w_fill_sum = fill_q + w_nbits;
    // Bits above the fill level are always zero, so OR-in is sufficient.
    assign w_acc_new  = acc_q | ({w_new, {OW{1'b0}}} >> fill_q);

    // ------------------------------------------------------------------
    // Configuration and accumulator next state
    // ------------------------------------------------------------------
    always_comb begin
        cfg_d     = cfg_q;
        cfg_err_d = cfg_err_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        w_done    = 1'b0;
        if (cfg_apply) begin
            cfg_d       = '0;
            cfg_d.bits  = cfg_bits;
            cfg_d.shift = cfg_shift;
            for (int k = 0; k < NCH; k++) cfg_d.mask[k] = cfg_mask[k];
            cfg_err_d   = cfg_invalid(cfg_d);
            acc_d       = '0;
            fill_d      = '0;
        end else if (in_en && !cfg_err_q) begin
            if (w_fill_sum >= C_OW_FILL) begin
                w_done = 1'b1;
                acc_d  = w_acc_new << OW;
                fill_d = w_fill_sum - C_OW_FILL;
            end else begin
                acc_d  = w_acc_new;
                fill_d = w_fill_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register, handshake and counters
    // ------------------------------------------------------------------
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        wc_d        = wc_q;
        if (w_done) begin
            // A same-cycle accept frees the register for the new word.
            if (!out_valid_q || out_ready) begin
                out_data_d  = w_acc_new[2*OW-1 -: OW];
                out_valid_d = 1'b1;
                wc_d        = wc_q + 16'd1;
            end else if (ovf_q != 16'hFFFF) begin
                ovf_d = ovf_q + 16'd1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_q       <= C_CFG_RST;
            cfg_err_q   <= C_ERR_RST;
            acc_q       <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= '0;
            wc_q        <= '0;
        end else begin
            cfg_q       <= cfg_d;
            cfg_err_q   <= cfg_err_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            wc_q        <= wc_d;
        end
    end

    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign cfg_err        = cfg_err_q;
    assign overflow_count = ovf_q;
    assign word_count     = wc_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_packer
//  Description : Self-checking bench for sample_packer. A bit-queue model
//                computes fields arithmetically and tracks the output
//                register, handshake and counters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sample_packer;

    localparam int NCH = 4;
    localparam int SW  = 8;
    localparam int OW  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [NCH*SW-1:0] in_i = '0;
    logic [NCH*SW-1:0] in_q = '0;
    logic              in_en = 1'b0;
    logic [NCH-1:0]    cfg_mask = '0;
    logic [1:0]        cfg_bits = '0;
    logic [2:0]        cfg_shift = '0;
    logic              cfg_apply = 1'b0;
    logic [OW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              cfg_err;
    logic [15:0]       overflow_count;
    logic [15:0]       word_count;

    int n_pass  = 0;
    int n_total = 0;

    sample_packer #(.NCH(NCH), .SW(SW), .OW(OW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_i           (in_i),
        .in_q           (in_q),
        .in_en          (in_en),
        .cfg_mask       (cfg_mask),
        .cfg_bits       (cfg_bits),
        .cfg_shift      (cfg_shift),
        .cfg_apply      (cfg_apply),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .cfg_err        (cfg_err),
        .overflow_count (overflow_count),
        .word_count     (word_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit           mq[$];
    logic         m_valid;
    logic [15:0]  m_data, m_wc, m_oc;
    logic [NCH-1:0] m_mask;
    int           m_b, m_shift;
    logic         m_err;

    function automatic int model_field(input int sample, input int b, input int shift);
        int s;
        s = (shift < SW - b) ? shift : SW - b;
        return (sample >> (SW - s - b)) & ((1 << b) - 1);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_valid = 1'b0; m_data = '0; m_wc = '0; m_oc = '0;
        m_mask  = '1;   m_b = 2;     m_shift = 0;
        m_err   = (4 * NCH > OW);
    endtask

    task automatic push_field(input int sample);
        int f;
        f = model_field(sample, m_b, m_shift);
        for (int j = m_b - 1; j >= 0; j--) mq.push_back(bit'((f >> j) & 1));
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        bit          done;
        logic [15:0] w;
        int          pop;
        @(posedge clk);
        done = 1'b0;
        w    = '0;
        if (cfg_apply) begin
            mq.delete();
            m_mask  = cfg_mask;
            m_b     = 1 << cfg_bits;
            m_shift = int'(cfg_shift);
            pop     = $countones(cfg_mask);
            m_err   = (pop == 0) || (2 * m_b * pop > OW);
        end else if (in_en && !m_err) begin
            for (int k = 0; k < NCH; k++) begin
                if (m_mask[k]) begin
                    push_field(int'(in_i[k*SW +: SW]));
                    push_field(int'(in_q[k*SW +: SW]));
                end
            end
            if (mq.size() >= OW) begin
                for (int j = 0; j < OW; j++) w = {w[14:0], mq.pop_front()};
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid || out_ready) begin
                m_data = w; m_valid = 1'b1; m_wc = m_wc + 16'd1;
            end else if (m_oc != 16'hFFFF) begin
                m_oc = m_oc + 16'd1;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic set_samples(input logic [7:0] iv, input logic [7:0] qv);
        for (int k = 0; k < NCH; k++) begin
            in_i[k*SW +: SW] = iv;
            in_q[k*SW +: SW] = qv;
        end
    endtask

    task automatic rand_samples();
        in_i = $urandom;
        in_q = $urandom;
    endtask

    // Apply a config, then scramble cfg_* to show they are ignored afterwards.
    task automatic apply_cfg(input logic [NCH-1:0] m, input logic [1:0] b, input logic [2:0] s);
        cfg_mask = m; cfg_bits = b; cfg_shift = s; cfg_apply = 1'b1; in_en = 1'b1;
        tick();
        cfg_apply = 1'b0; in_en = 1'b0;
        cfg_mask = NCH'($urandom); cfg_bits = 2'($urandom); cfg_shift = 3'($urandom);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
        n_total++; if (out_data !== 16'h0) $display("FAIL reset_data got=%h exp=0000", out_data); else n_pass++;
        n_total++; if (word_count !== 16'h0) $display("FAIL reset_wc got=%0d exp=0", word_count); else n_pass++;
        n_total++; if (overflow_count !== 16'h0) $display("FAIL reset_oc got=%0d exp=0", overflow_count); else n_pass++;
        n_total++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); else n_pass++;
        @(posedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_config();
        out_ready = 1'b1;
        set_samples(8'hC0, 8'h40);
        in_en = 1'b1;
        tick();
        n_total++; if (out_valid !== 1'b1) $display("FAIL rc_valid1 got=%b exp=1", out_valid); else n_pass++;
        n_total++; if (out_data !== 16'hDDDD) $display("FAIL rc_data1 got=%h exp=dddd", out_data); else n_pass++;
        tick();
        in_en = 1'b0;
        n_total++; if (out_data !== m_data) $display("FAIL rc_data2 got=%h exp=%h", out_data, m_data); else n_pass++;
        n_total++; if (word_count !== m_wc) $display("FAIL rc_wc got=%0d exp=%0d", word_count, m_wc); else n_pass++;
        tick();
    endtask

    task automatic test_b8_single();
        apply_cfg(4'b0001, 2'd3, 3'd0);
        n_total++; if (cfg_err !== 1'b0) $display("FAIL b8_cfg_err got=%b exp=0", cfg_err); else n_pass++;
        rand_samples();
        in_i[SW-1:0] = 8'hA5; in_q[SW-1:0] = 8'h3C;
        in_en = 1'b1;
        tick();
        in_en = 1'b0;
        n_total++; if (out_valid !== 1'b1) $display("FAIL b8_valid got=%b exp=1", out_valid); else n_pass++;
        n_total++; if (out_data !== 16'hA53C) $display("FAIL b8_data got=%h exp=a53c", out_data); else n_pass++;
        tick();
    endtask

    task automatic test_p12();
        logic [15:0] wc0;
        apply_cfg(4'b0111, 2'd1, 3'd0);
        wc0 = word_count;
        for (int c = 0; c < 4; c++) begin
            rand_samples(); in_en = 1'b1;
            tick();
            n_total++; if (out_data !== m_data || out_valid !== m_valid)
                $display("FAIL p12_out c=%0d got=%h/%b exp=%h/%b", c, out_data, out_valid, m_data, m_valid); else n_pass++;
        end
        in_en = 1'b0;
        n_total++; if (word_count - wc0 !== 16'd3) $display("FAIL p12_words got=%0d exp=3", word_count - wc0); else n_pass++;
        // Empty accumulator: a full-word pattern next must land word-aligned.
        apply_cfg(4'b0001, 2'd3, 3'd0);
        set_samples(8'h5A, 8'hC3); in_en = 1'b1;
        tick(); in_en = 1'b0;
        n_total++; if (out_data !== 16'h5AC3) $display("FAIL p12_align got=%h exp=5ac3", out_data); else n_pass++;
        tick();
    endtask

    task automatic test_overflow();
        logic [15:0] oc0;
        apply_cfg(4'b1111, 2'd1, 3'd0);
        oc0 = overflow_count;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rand_samples(); in_en = 1'b1;
            tick();
        end
        in_en = 1'b0;
        n_total++; if (out_data !== m_data) $display("FAIL ovf_held got=%h exp=%h", out_data, m_data); else n_pass++;
        n_total++; if (overflow_count - oc0 !== 16'd2) $display("FAIL ovf_count got=%0d exp=2", overflow_count - oc0); else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL ovf_release got=%b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_cfg_err();
        logic [15:0] wc0;
        apply_cfg(4'b0011, 2'd3, 3'd0);
        n_total++; if (cfg_err !== 1'b1) $display("FAIL err_flag got=%b exp=1", cfg_err); else n_pass++;
        wc0 = word_count;
        for (int c = 0; c < 10; c++) begin
            rand_samples(); in_en = 1'b1;
            tick();
        end
        in_en = 1'b0;
        n_total++; if (word_count !== wc0 || out_valid !== 1'b0)
            $display("FAIL err_nowords got=%0d/%b exp=%0d/0", word_count, out_valid, wc0); else n_pass++;
        apply_cfg(4'b0011, 2'd1, 3'd0);
        n_total++; if (cfg_err !== 1'b0) $display("FAIL err_clear got=%b exp=0", cfg_err); else n_pass++;
    endtask

    task automatic test_apply_midword();
        // P = 8: one sample leaves a half word that must be discarded.
        set_samples(8'h00, 8'h00); in_en = 1'b1;
        tick();
        apply_cfg(4'b0011, 2'd1, 3'd0);
        set_samples(8'hC0, 8'h40); in_en = 1'b1;
        tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_early got=%b exp=0", out_valid); else n_pass++;
        tick();
        in_en = 1'b0;
        n_total++; if (out_data !== 16'hDDDD) $display("FAIL mid_data got=%h exp=dddd", out_data); else n_pass++;
        tick();
    endtask

    task automatic test_reset_midword();
        set_samples(8'hFF, 8'hFF); in_en = 1'b1;
        tick();
        in_en = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        set_samples(8'h80, 8'h00); in_en = 1'b1;
        tick();
        in_en = 1'b0;
        n_total++; if (out_data !== m_data || out_valid !== 1'b1)
            $display("FAIL rstmid got=%h/%b exp=%h/1", out_data, out_valid, m_data); else n_pass++;
        n_total++; if (out_data !== 16'h8888) $display("FAIL rstmid_lit got=%h exp=8888", out_data); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            rand_samples();
            in_en     = ($urandom_range(0, 99) < 75);
            out_ready = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 5) begin
                cfg_apply = 1'b1;
                cfg_mask  = NCH'($urandom);
                cfg_bits  = 2'($urandom_range(0, 2));
                cfg_shift = 3'($urandom);
            end else begin
                cfg_apply = 1'b0;
            end
            tick();
            n_total++;
            if (out_valid !== m_valid || out_data !== m_data || word_count !== m_wc ||
                overflow_count !== m_oc || cfg_err !== m_err) begin
                if (bad < 10)
                    $display("FAIL rand c=%0d got v=%b d=%h wc=%0d oc=%0d e=%b exp v=%b d=%h wc=%0d oc=%0d e=%b",
                             c, out_valid, out_data, word_count, overflow_count, cfg_err,
                             m_valid, m_data, m_wc, m_oc, m_err);
                bad++;
            end else begin
                n_pass++;
            end
        end
        cfg_apply = 1'b0; in_en = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_config();
        test_b8_single();
        test_p12();
        test_overflow();
        test_cfg_err();
        test_apply_midword();
        test_reset_midword();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
